prog_mem_loader: RTL and testbench
==================================

Name: prog_mem_loader

Overview:
Parametrised successor to the fixed per-level program ROMs. It holds one program image in a DEPTH x DATA_W array and serves instruction fetches through a registered read port. After reset it clears itself to zero, so unwritten words read as zero, matching the old ROM default. It then accepts a new level image over a byte-stream valid/ready load port, which replaces regenerating a ROM module for every level.

Parameters:
DATA_W, 8, instruction word width in bits; also the load_data width.
ADDR_W, 8, address width in bits.
DEPTH, 2**ADDR_W, number of words; must be a power of two no larger than 2**ADDR_W.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst_n  in  1  asynchronous, active-low reset.
load_start  in  1  one-cycle pulse that begins an image load; honoured only in RUN.
load_valid  in  1  load_data is valid this cycle.
load_data  in  DATA_W  next image word; words are written from address 0 upward.
load_last  in  1  qualifies the final word of the image.
load_ready  out  1  block accepts a load word this cycle.
load_done  out  1  one-cycle pulse when a load completes.
rd_en  in  1  fetch request.
rd_addr  in  ADDR_W  fetch address.
rd_data  out  DATA_W  fetched word, registered.
rd_valid  out  1  rd_data holds a fetch result this cycle.
busy  out  1  high while in CLEAR or LOAD.

Behaviour:
- Reset values: state=CLEAR, wr_ptr=0, load_ready=0, load_done=0, rd_data=0, rd_valid=0, busy=1. Array contents are not reset directly; CLEAR zeroes them.
- States:
  - CLEAR: writes 0 to mem[wr_ptr] each cycle and increments wr_ptr. Exits to RUN in the cycle that writes address DEPTH-1, so CLEAR lasts exactly DEPTH cycles. busy=1.
  - RUN: busy=0, load_ready=0.
    - A fetch has latency 1: rd_en=1 at edge N gives rd_data=mem[rd_addr] and rd_valid=1 after edge N+1.
    - rd_en=0 gives rd_valid=0, and rd_data holds its last value.
    - Addresses >= DEPTH return 0, with rd_valid still 1.
    - load_start=1 sets wr_ptr=0 and enters LOAD. A fetch requested in the same cycle is still served.
  - LOAD: busy=1, load_ready=1.
    - Each cycle with load_valid&load_ready writes mem[wr_ptr]=load_data and increments wr_ptr.
    - Exit to RUN with load_done=1 on the next cycle when the accepted word has load_last=1, or when the accepted word is at wr_ptr=DEPTH-1 (image full; load_last is ignored).
    - Words beyond the last accepted address keep their previous contents; there is no implicit clear.
    - A load of a single word (load_last on the first beat) is legal.
- rd_en is ignored during CLEAR and LOAD: rd_valid=0 and rd_data is forced to 0.
- load_start is ignored in CLEAR and LOAD; no restart mid-load.
- load_valid outside LOAD is ignored and writes nothing.
- Assertion of rst_n low mid-load or mid-clear aborts immediately and returns to CLEAR. Partial images are discarded by the re-clear.
- wr_ptr is ADDR_W+1 bits wide internally so the DEPTH-1 test does not alias when DEPTH=2**ADDR_W.
- Array: a single write port and a single synchronous read port, inferable as block RAM. Write and read never coexist because reads are gated outside RUN.

Decomposition:
- Package prog_mem_pkg holds typedef enum logic [1:0] {CLEAR, RUN, LOAD} prog_mem_state_t and the default DATA_W/ADDR_W localparams shared with the CPU fetch unit.
- One sub-module, prog_mem_array: parametrised 1W1R synchronous RAM with a registered read. The FSM and pointer stay in prog_mem_loader.

Test Plan:
- Reset then wait: busy=1 for exactly 256 cycles (defaults), then busy=0. Reads of 0x00, 0x7F and 0xFF all return 0x00 with rd_valid one cycle later.
- Load of 24 words: pulse load_start, stream a 24-word image with load_last on the 24th word. Require load_done exactly once, rd 0x0D -> 0xB3, rd 0x17 -> 0xC4, rd 0x18 -> 0x00.
- Backpressure-free gaps: the same stream with load_valid dropped every other cycle. Same contents, and wr_ptr advances only on accepted beats.
- Overflow: stream 300 words with no load_last. The load ends after word 256 with load_done, load_ready falls, and the remaining 44 words are not written (mem[0] still holds word 0).
- Partial reload: after a full 0xAA image, load 2 words (0x11, 0x22). Then rd 0x00=0x11, 0x01=0x22, 0x02=0xAA.
- Async reset at load beat 10: rst_n low mid-cycle forces busy=1 and load_ready=0 immediately. After CLEAR, every address reads 0x00.
- Fetch gating: rd_en held high during LOAD gives rd_valid=0 and rd_data=0. In the first RUN cycle, rd_valid rises one cycle after rd_en is sampled.

Source files
------------

// File: rtl/prog_mem_pkg.sv
// Types and default geometry shared by the program memory loader and the CPU fetch unit.
// No logic here; latency and backpressure are defined by the modules that import it.
// The CLEAR/RUN/LOAD encoding is used by the loader FSM.
package prog_mem_pkg;

    localparam int PROG_DATA_W = 8;
    localparam int PROG_ADDR_W = 8;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } prog_mem_state_t;

endpackage

// File: rtl/prog_mem_array.sv
// Single-port-write, single-port-read synchronous RAM with a registered read data output.
// Read latency 1 cycle: rdata updates on the edge that samples re, and holds otherwise.
// No flow control; the caller keeps write and read from overlapping.
module prog_mem_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the storage or the read register so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/prog_mem_loader.sv
// Program image store: self-clears after reset, then serves fetches and accepts byte-stream reloads.
// Fetch latency 1 cycle; CLEAR takes DEPTH cycles; a load takes one cycle per accepted word.
// load_ready is high for the whole of LOAD; fetches are answered only in RUN.
module prog_mem_loader
    import prog_mem_pkg::*;
#(
    parameter int DATA_W = PROG_DATA_W,
    parameter int ADDR_W = PROG_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = ADDR_W + 1;

    // The extra pointer bit keeps DEPTH-1 and DEPTH distinct when DEPTH == 2**ADDR_W.
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(DEPTH);

    prog_mem_state_t   state;
    prog_mem_state_t   state_nxt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  wr_ptr_nxt;
    logic              load_done_nxt;

    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    logic              rd_in_range;
    logic              rd_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            wr_ptr    <= '0;
            load_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            load_done <= load_done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        load_done_nxt = 1'b0;
        mem_we        = 1'b0;
        mem_wdata     = '0;
        load_ready    = 1'b0;
        busy          = 1'b1;

        case (state)
            CLEAR: begin
                mem_we     = 1'b1;
                wr_ptr_nxt = wr_ptr + PTR_W'(1);
                if (wr_ptr == LAST_PTR) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b0;
                if (load_start) begin
                    wr_ptr_nxt = '0;
                    state_nxt  = LOAD;
                end
            end
            LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    mem_we     = 1'b1;
                    mem_wdata  = load_data;
                    wr_ptr_nxt = wr_ptr + PTR_W'(1);
                    // A full image ends the load regardless of load_last.
                    if (load_last || (wr_ptr == LAST_PTR)) begin
                        state_nxt     = RUN;
                        load_done_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = CLEAR;
                wr_ptr_nxt = '0;
            end
        endcase
    end

    assign mem_re      = (state == RUN) && rd_en;
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_PTR);

    // rd_zero masks the RAM output: forced zero outside RUN and for out-of-range fetches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_zero  <= 1'b1;
        end else begin
            rd_valid <= mem_re;
            if (state != RUN) begin
                rd_zero <= 1'b1;
            end else if (rd_en) begin
                rd_zero <= !rd_in_range;
            end
        end
    end

    assign rd_data = rd_zero ? '0 : mem_rdata;

    prog_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (rd_addr[AW-1:0]),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader at default geometry (8-bit words, 256 entries).
module tb_prog_mem_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_start = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       load_last = 1'b0;
    logic       load_ready;
    logic       load_done;
    logic       rd_en = 1'b0;
    logic [7:0] rd_addr = 8'h00;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;

    int vec_cnt = 0;
    int miscmp  = 0;

    logic [7:0] img [300];
    logic [7:0] img24 [24] = '{8'h3C, 8'h41, 8'h5A, 8'h07, 8'h12, 8'h9E, 8'h66, 8'h01,
                               8'hF0, 8'h2B, 8'h88, 8'h74, 8'h19, 8'hB3, 8'h50, 8'hCD,
                               8'h0E, 8'h37, 8'hA2, 8'h6B, 8'h95, 8'hD8, 8'h4F, 8'hC4};

    prog_mem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_done  (load_done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        rd_en   = 1'b1;
        rd_addr = a;
        @(posedge clk); #1;
        rd_en = 1'b0;
        chk({tag, "_vld"}, {31'd0, rd_valid}, 32'd1);
        chk(tag, {24'd0, rd_data}, {24'd0, exp});
    endtask

    task automatic start_load(input string tag);
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        chk({tag, "_ready"}, {31'd0, load_ready}, 32'd1);
    endtask

    // Drives n words from img; gapped mode idles every odd cycle with a tempting load_last.
    task automatic stream(input int n, input bit gapped, input bit use_last,
                          output int dones, output int done_at, output int ready_fall);
        int beat = 0;
        int cyc  = 0;
        dones = 0; done_at = -1; ready_fall = -1;
        while (beat < n && cyc < 2000) begin
            if (gapped && cyc[0]) begin
                load_valid = 1'b0; load_data = 8'hFF; load_last = 1'b1;
            end else begin
                load_valid = 1'b1; load_data = img[beat];
                load_last  = use_last && (beat == n - 1);
            end
            @(posedge clk); #1;
            if (load_valid) beat++;
            if (load_done) begin dones++; done_at = cyc; end
            if (!load_ready && ready_fall < 0) ready_fall = beat;
            cyc++;
        end
        load_valid = 1'b0; load_last = 1'b0;
        if (beat < n) chk("stream_timeout", beat, n);
    endtask

    task automatic wait_run(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (busy && cycles < 2000);
        if (busy) chk("run_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dones, done_at, rfall;
        logic [7:0] or_all;
        logic       vld_all;

        // Reset state
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_done", {31'd0, load_done}, 32'd0);
        chk("rst_rvld", {31'd0, rd_valid}, 32'd0);
        chk("rst_rdat", {24'd0, rd_data}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_run(n);
        chk("clear_cycles", n, 256);
        rd_chk("clr_00", 8'h00, 8'h00);
        rd_chk("clr_7f", 8'h7F, 8'h00);
        rd_chk("clr_ff", 8'hFF, 8'h00);

        // 24-word load
        for (int i = 0; i < 24; i++) img[i] = img24[i];
        start_load("l24");
        stream(24, 1'b0, 1'b1, dones, done_at, rfall);
        chk("l24_dones", dones, 1);
        chk("l24_done_at", done_at, 23);
        rd_chk("l24_0d", 8'h0D, 8'hB3);
        @(posedge clk); #1;
        chk("hold_vld", {31'd0, rd_valid}, 32'd0);
        chk("hold_dat", {24'd0, rd_data}, 32'hB3);
        rd_chk("l24_17", 8'h17, 8'hC4);
        rd_chk("l24_18", 8'h18, 8'h00);

        // Overflow: 300 words, no load_last
        for (int i = 0; i < 300; i++) img[i] = (i < 256) ? 8'(i * 3 + 5) : 8'hEE;
        start_load("ovf");
        stream(300, 1'b0, 1'b0, dones, done_at, rfall);
        chk("ovf_dones", dones, 1);
        chk("ovf_done_at", done_at, 255);
        chk("ovf_ready_fall", rfall, 256);
        chk("ovf_ready", {31'd0, load_ready}, 32'd0);
        rd_chk("ovf_00", 8'h00, 8'h05);
        rd_chk("ovf_2b", 8'h2B, 8'h86);
        rd_chk("ovf_ff", 8'hFF, 8'h02);

        // Gapped stream of the 24-word image over the overflow contents
        for (int i = 0; i < 24; i++) img[i] = img24[i];
        start_load("gap");
        stream(24, 1'b1, 1'b1, dones, done_at, rfall);
        chk("gap_dones", dones, 1);
        chk("gap_done_at", done_at, 46);
        rd_chk("gap_00", 8'h00, 8'h3C);
        rd_chk("gap_0d", 8'h0D, 8'hB3);
        rd_chk("gap_17", 8'h17, 8'hC4);
        rd_chk("gap_18", 8'h18, 8'h4D);

        // load_valid in RUN must write nothing
        load_valid = 1'b1; load_data = 8'h99; load_last = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0; load_last = 1'b0;
        chk("run_lv_done", {31'd0, load_done}, 32'd0);
        chk("run_lv_busy", {31'd0, busy}, 32'd0);
        rd_chk("run_lv_00", 8'h00, 8'h3C);

        // Partial reload over a full 0xAA image
        for (int i = 0; i < 256; i++) img[i] = 8'hAA;
        start_load("aa");
        stream(256, 1'b0, 1'b1, dones, done_at, rfall);
        chk("aa_done_at", done_at, 255);
        img[0] = 8'h11; img[1] = 8'h22;
        start_load("p2");
        stream(2, 1'b0, 1'b1, dones, done_at, rfall);
        chk("p2_done_at", done_at, 1);
        rd_chk("p2_00", 8'h00, 8'h11);
        rd_chk("p2_01", 8'h01, 8'h22);
        rd_chk("p2_02", 8'h02, 8'hAA);
        rd_chk("p2_ff", 8'hFF, 8'hAA);

        // Fetch alongside load_start is served; fetches during LOAD are gated
        rd_en = 1'b1; rd_addr = 8'h00; load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        chk("ls_rvld", {31'd0, rd_valid}, 32'd1);
        chk("ls_rdat", {24'd0, rd_data}, 32'h11);
        chk("ls_ready", {31'd0, load_ready}, 32'd1);
        rd_addr = 8'h02;
        for (int b = 0; b < 3; b++) begin
            load_valid = 1'b1; load_data = 8'(8'h31 + b); load_last = (b == 2);
            @(posedge clk); #1;
            chk($sformatf("gate_rvld%0d", b), {31'd0, rd_valid}, 32'd0);
            chk($sformatf("gate_rdat%0d", b), {24'd0, rd_data}, 32'd0);
        end
        load_valid = 1'b0; load_last = 1'b0;
        chk("gate_done", {31'd0, load_done}, 32'd1);
        @(posedge clk); #1;
        rd_en = 1'b0;
        chk("first_run_rvld", {31'd0, rd_valid}, 32'd1);
        chk("first_run_rdat", {24'd0, rd_data}, 32'h33);

        // Async reset at load beat 10
        for (int i = 0; i < 16; i++) img[i] = 8'h5A;
        start_load("ar");
        for (int b = 0; b < 10; b++) begin
            load_valid = 1'b1; load_data = 8'h5A;
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", {31'd0, busy}, 32'd1);
        chk("ar_ready", {31'd0, load_ready}, 32'd0);
        load_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        wait_run(n);
        chk("ar_clear_cycles", n, 256);
        or_all = 8'h00; vld_all = 1'b1;
        for (int a = 0; a < 256; a++) begin
            rd_en = 1'b1; rd_addr = 8'(a);
            @(posedge clk); #1;
            or_all  = or_all | rd_data;
            vld_all = vld_all & rd_valid;
        end
        rd_en = 1'b0;
        chk("ar_all_zero", {24'd0, or_all}, 32'd0);
        chk("ar_all_vld", {31'd0, vld_all}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
